// File: rtl/curtain_pkg.sv
// Shared definitions for the curtain stepper: controller states and the
// half-step coil table.
package curtain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OPEN   = 3'd1,
        ST_CLOSE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    // Half-step sequence, bit3..bit0 = A, B, A', B'. Rising index = opening.
    localparam logic [3:0] HALF_STEP [8] = '{
        4'b1000, 4'b1100, 4'b0100, 4'b0110,
        4'b0010, 4'b0011, 4'b0001, 4'b1001
    };

    // Coils are energised only while moving or settling.
    function automatic logic [3:0] coil_drive(input state_t st, input logic [2:0] idx);
        if (st == ST_IDLE || st == ST_FAULT) begin
            return 4'b0000;
        end
        return HALF_STEP[idx];
    endfunction

endpackage

// File: rtl/limit_sync.sv
// Two-flop synchronizer for an asynchronous end-stop switch.
module limit_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic sync_p0;
    logic sync_p1;

    // Metastability guard: first flop may go metastable, second resolves it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= async_in;
            sync_p1 <= sync_p0;
        end
    end

    assign sync_out = sync_p1;

endmodule

// File: rtl/curtain_stepper.sv
// Curtain stepper controller: paces a half-step motor from step_tick, tracks
// position, honours end-stops, settles before reversing and faults on stall.
module curtain_stepper
    import curtain_pkg::*;
#(
    parameter int MAX_POS      = 2048,
    parameter int SETTLE_TICKS = 50,
    parameter int MARGIN       = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_tick,
    input  logic        cmd_open,
    input  logic        cmd_close,
    input  logic        cmd_stop,
    input  logic        limit_open,
    input  logic        limit_closed,
    output logic [3:0]  phase,
    output logic [11:0] position,
    output logic        busy,
    output logic        fault
);

    localparam logic [11:0] POS_MAX     = 12'(MAX_POS);
    localparam logic [15:0] TICK_LIM    = 16'(MAX_POS + MARGIN);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_TICKS - 1);

    logic        lim_open_s;
    logic        lim_closed_s;

    state_t      st, st_n;
    state_t      tgt, tgt_n;
    logic [2:0]  idx, idx_n;
    logic [11:0] pos_n;
    logic [15:0] tick_cnt, cnt_n;
    logic [7:0]  settle_cnt, set_n;

    logic        stop;
    logic        open_ok;
    logic        close_ok;

    limit_sync u_sync_open (
        .clk      (clk),
        .rst      (rst),
        .async_in (limit_open),
        .sync_out (lim_open_s)
    );

    limit_sync u_sync_closed (
        .clk      (clk),
        .rst      (rst),
        .async_in (limit_closed),
        .sync_out (lim_closed_s)
    );

    // Conflicting open+close behaves as stop; moves toward a reached end are refused.
    assign stop     = cmd_stop | (cmd_open & cmd_close);
    assign open_ok  = cmd_open  & (position != POS_MAX) & ~lim_open_s;
    assign close_ok = cmd_close & (position != 12'd0)   & ~lim_closed_s;

    // Next-state decode: stop first, then end-stops, then reversal, then stepping.
    always_comb begin
        st_n  = st;
        tgt_n = tgt;
        idx_n = idx;
        pos_n = position;
        cnt_n = tick_cnt;
        set_n = settle_cnt;
        case (st)
            ST_IDLE: begin
                if (!stop && open_ok) begin
                    st_n  = ST_OPEN;
                    cnt_n = 16'd0;
                end else if (!stop && close_ok) begin
                    st_n  = ST_CLOSE;
                    cnt_n = 16'd0;
                end
            end
            ST_OPEN: begin
                if (stop) begin
                    st_n = ST_IDLE;
                end else if (lim_open_s || position == POS_MAX) begin
                    st_n  = ST_IDLE;
                    pos_n = POS_MAX;
                end else if (close_ok) begin
                    st_n  = ST_SETTLE;
                    tgt_n = ST_CLOSE;
                    set_n = 8'd0;
                end else if (step_tick) begin
                    if (tick_cnt == TICK_LIM) begin
                        st_n = ST_FAULT;
                    end else begin
                        cnt_n = tick_cnt + 16'd1;
                        idx_n = idx + 3'd1;
                        pos_n = position + 12'd1;
                    end
                end
            end
            ST_CLOSE: begin
                if (stop) begin
                    st_n = ST_IDLE;
                end else if (lim_closed_s || position == 12'd0) begin
                    st_n  = ST_IDLE;
                    pos_n = 12'd0;
                end else if (open_ok) begin
                    st_n  = ST_SETTLE;
                    tgt_n = ST_OPEN;
                    set_n = 8'd0;
                end else if (step_tick) begin
                    if (tick_cnt == TICK_LIM) begin
                        st_n = ST_FAULT;
                    end else begin
                        cnt_n = tick_cnt + 16'd1;
                        idx_n = idx - 3'd1;
                        pos_n = position - 12'd1;
                    end
                end
            end
            ST_SETTLE: begin
                if (stop) begin
                    st_n = ST_IDLE;
                end else if (step_tick) begin
                    if (settle_cnt == SETTLE_LAST) begin
                        st_n  = tgt;
                        cnt_n = 16'd0;
                    end else begin
                        set_n = settle_cnt + 8'd1;
                    end
                end
            end
            ST_FAULT: begin
                if (stop) begin
                    st_n = ST_IDLE;
                end
            end
            default: st_n = ST_IDLE;
        endcase
    end

    // State, counters and registered coil/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= ST_IDLE;
            tgt        <= ST_IDLE;
            idx        <= 3'd0;
            position   <= 12'd0;
            tick_cnt   <= 16'd0;
            settle_cnt <= 8'd0;
            phase      <= 4'b0000;
            busy       <= 1'b0;
            fault      <= 1'b0;
        end else begin
            st         <= st_n;
            tgt        <= tgt_n;
            idx        <= idx_n;
            position   <= pos_n;
            tick_cnt   <= cnt_n;
            settle_cnt <= set_n;
            phase      <= coil_drive(st_n, idx_n);
            busy       <= (st_n == ST_OPEN) || (st_n == ST_CLOSE) || (st_n == ST_SETTLE);
            fault      <= (st_n == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_curtain_stepper.sv
// Directed bench for curtain_stepper with MAX_POS=16, SETTLE_TICKS=4, MARGIN=8.
module tb_curtain_stepper;

    logic        clk = 1'b0;
    logic        rst;
    logic        step_tick;
    logic        cmd_open;
    logic        cmd_close;
    logic        cmd_stop;
    logic        limit_open;
    logic        limit_closed;
    logic [3:0]  phase;
    logic [11:0] position;
    logic        busy;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] tbl [8] = '{4'h8, 4'hC, 4'h4, 4'h6, 4'h2, 4'h3, 4'h1, 4'h9};

    curtain_stepper #(
        .MAX_POS      (16),
        .SETTLE_TICKS (4),
        .MARGIN       (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .step_tick    (step_tick),
        .cmd_open     (cmd_open),
        .cmd_close    (cmd_close),
        .cmd_stop     (cmd_stop),
        .limit_open   (limit_open),
        .limit_closed (limit_closed),
        .phase        (phase),
        .position     (position),
        .busy         (busy),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    // step_tick: one clk high out of every 10, changed on falling edges
    initial begin
        step_tick = 1'b0;
        forever begin
            repeat (9) @(negedge clk);
            step_tick = 1'b1;
            @(negedge clk);
            step_tick = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for the next clock edge that consumes a step_tick, then sample 1 time unit later.
    task automatic wait_tick();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            if (step_tick) got = 1'b1;
        end
        #1;
        check("tick_seen", 32'(got), 32'd1);
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        case (which)
            0: cmd_open = 1'b1;
            1: cmd_close = 1'b1;
            2: cmd_stop = 1'b1;
            default: begin cmd_open = 1'b1; cmd_close = 1'b1; end
        endcase
        @(negedge clk);
        cmd_open  = 1'b0;
        cmd_close = 1'b0;
        cmd_stop  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cmd_open = 1'b0; cmd_close = 1'b0; cmd_stop = 1'b0;
        limit_open = 1'b0; limit_closed = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_phase", 32'(phase), 32'h0);
        check("rst_pos", 32'(position), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        rst = 1'b0;

        // Full open from closed
        pulse(0);
        check("open_entry_busy", 32'(busy), 32'd1);
        check("open_entry_phase", 32'(phase), 32'h8);
        for (int k = 1; k <= 16; k++) begin
            wait_tick();
            check("open_pos", 32'(position), 32'(k));
            check("open_phase", 32'(phase), 32'(tbl[3'(k)]));
        end
        @(posedge clk); #1;
        check("open_end_busy", 32'(busy), 32'd0);
        check("open_end_phase", 32'(phase), 32'h0);
        check("open_end_pos", 32'(position), 32'd16);

        // Full close from open
        pulse(1);
        check("close_entry_busy", 32'(busy), 32'd1);
        check("close_entry_phase", 32'(phase), 32'h8);
        for (int k = 1; k <= 16; k++) begin
            wait_tick();
            check("close_pos", 32'(position), 32'(16 - k));
            check("close_phase", 32'(phase), 32'(tbl[3'(16 - k)]));
        end
        @(posedge clk); #1;
        check("close_end_busy", 32'(busy), 32'd0);
        check("close_end_phase", 32'(phase), 32'h0);
        pulse(1);
        check("close_at0_busy", 32'(busy), 32'd0);
        wait_tick();
        check("close_at0_pos", 32'(position), 32'd0);

        // Reversal at position 8: hold 4 ticks then count down
        pulse(0);
        for (int k = 1; k <= 8; k++) wait_tick();
        check("rev_start_pos", 32'(position), 32'd8);
        pulse(1);
        check("rev_settle_busy", 32'(busy), 32'd1);
        check("rev_settle_phase", 32'(phase), 32'h8);
        for (int k = 1; k <= 4; k++) begin
            wait_tick();
            check("rev_hold_pos", 32'(position), 32'd8);
            check("rev_hold_phase", 32'(phase), 32'h8);
        end
        wait_tick();
        check("rev_pos7", 32'(position), 32'd7);
        check("rev_phase7", 32'(phase), 32'h9);
        wait_tick();
        check("rev_pos6", 32'(position), 32'd6);
        check("rev_phase6", 32'(phase), 32'h1);
        wait_tick();
        check("rev_pos5", 32'(position), 32'd5);
        check("rev_phase5", 32'(phase), 32'h3);
        pulse(2);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_phase", 32'(phase), 32'h0);
        check("stop_pos", 32'(position), 32'd5);

        // Open end-stop hit at position 5, two-flop latency
        pulse(0);
        limit_open = 1'b1;
        @(posedge clk); #1;
        check("lim_sync1_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("lim_sync2_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("lim_hit_busy", 32'(busy), 32'd0);
        check("lim_hit_pos", 32'(position), 32'd16);
        check("lim_hit_phase", 32'(phase), 32'h0);
        pulse(0);
        check("lim_open_ignored", 32'(busy), 32'd0);
        limit_open = 1'b0;
        repeat (3) @(negedge clk);

        // Stall: position held away from 0 while closing
        pulse(1);
        check("stall_entry_busy", 32'(busy), 32'd1);
        force dut.position = 12'd200;
        for (int k = 1; k <= 24; k++) wait_tick();
        check("stall_24_fault", 32'(fault), 32'd0);
        check("stall_24_busy", 32'(busy), 32'd1);
        wait_tick();
        check("stall_25_fault", 32'(fault), 32'd1);
        check("stall_25_busy", 32'(busy), 32'd0);
        check("stall_25_phase", 32'(phase), 32'h0);
        pulse(2);
        check("fault_clear", 32'(fault), 32'd0);
        check("fault_clear_busy", 32'(busy), 32'd0);
        release dut.position;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("rst2_pos", 32'(position), 32'd0);

        // Asynchronous reset mid-open
        pulse(0);
        for (int k = 1; k <= 7; k++) wait_tick();
        check("mid_pos", 32'(position), 32'd7);
        check("mid_phase", 32'(phase), 32'h9);
        #1 rst = 1'b1;
        #1;
        check("async_rst_phase", 32'(phase), 32'h0);
        check("async_rst_pos", 32'(position), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk); rst = 1'b0;
        wait_tick();
        check("post_rst_phase", 32'(phase), 32'h0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Simultaneous open and close behaves as stop
        pulse(3);
        check("both_busy", 32'(busy), 32'd0);
        wait_tick();
        check("both_pos", 32'(position), 32'd0);
        check("both_phase", 32'(phase), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
